// File: rtl/imem_port_arbiter_pkg.sv
// Shared definitions for the instruction-memory port arbiter: default
// address width, the flush NOP encoding and the port-owner state encoding.
package imem_port_arbiter_pkg;

    localparam int          ADDR_W_DEF    = 8;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h00000013;

    // Who owned the memory port in the previous cycle, i.e. who the
    // returning read data belongs to.
    typedef enum logic [1:0] {
        OWN_NONE    = 2'd0,
        OWN_FETCH   = 2'd1,
        OWN_LOAD_RD = 2'd2
    } owner_e;

endpackage

// File: rtl/imem_wait_counter.sv
// Saturating starvation counter for the loader port. Counts the cycles a
// valid loader request has been refused, saturating at MAX_WAIT; a clear
// takes priority over counting.
module imem_wait_counter #(
    parameter int MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_i,
    input  logic       clr_i,
    output logic [3:0] cnt_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Next count: clear wins, otherwise count up until saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (inc_i && (cnt_q != 4'(MAX_WAIT))) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbiter for the single synchronous-read instruction memory port, shared
// between instruction fetch (priority) and the program-loader/debug port.
// A starvation counter forces a waiting loader through after MAX_WAIT
// refused cycles. Read data returns one cycle after the grant and is
// steered to whichever requester owned the port in the grant cycle.
module imem_port_arbiter
    import imem_port_arbiter_pkg::*;
#(
    parameter int          ADDR_W    = ADDR_W_DEF,
    parameter int          MAX_WAIT  = 4,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_pc,
    input  logic              fetch_flush,
    output logic              fetch_stall,
    output logic              fetch_valid,
    output logic [31:0]       fetch_instr,
    input  logic              ld_valid,
    input  logic              ld_we,
    input  logic [31:0]       ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              ld_ready,
    output logic              ld_rvalid,
    output logic [31:0]       ld_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    owner_e      owner_q;
    owner_e      owner_d;
    logic        flush_pending_q;
    logic [31:0] fetch_instr_q;
    logic [31:0] ld_rdata_q;
    logic [3:0]  wait_cnt;
    logic        wait_sat;
    logic        ld_win;
    logic        fetch_win;

    // Byte-offset bits and address bits above the memory are dropped, so
    // addresses wrap modulo the memory size.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{fetch_pc[31:ADDR_W+2], fetch_pc[1:0],
                                ld_addr[31:ADDR_W+2], ld_addr[1:0]};

    imem_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .clk   (clk),
        .rst   (rst),
        .inc_i (ld_valid && !ld_win),
        .clr_i (ld_win || !ld_valid),
        .cnt_o (wait_cnt)
    );

    assign wait_sat = (wait_cnt == 4'(MAX_WAIT));

    // Grant decision: loader takes the port when fetch is absent or the
    // loader has waited long enough; nothing is granted while in reset.
    always_comb begin
        ld_win    = !rst && ld_valid && (!fetch_req || wait_sat);
        fetch_win = !rst && fetch_req && !ld_win;
    end

    // Memory port drive and handshake outputs for the grant cycle.
    always_comb begin
        ld_ready    = ld_win;
        fetch_stall = !rst && fetch_req && !fetch_win;
        mem_en      = ld_win || fetch_win;
        mem_we      = ld_win && ld_we;
        mem_addr    = ld_win ? ld_addr[ADDR_W+1:2] : fetch_pc[ADDR_W+1:2];
        mem_wdata   = ld_wdata;
    end

    // Owner next state: who the data coming back next cycle belongs to.
    // Loader writes produce no response, so they leave the port unowned.
    always_comb begin
        owner_d = OWN_NONE;
        if (fetch_win) begin
            owner_d = OWN_FETCH;
        end else if (ld_win && !ld_we) begin
            owner_d = OWN_LOAD_RD;
        end
    end

    // Owner register plus a record of a flush that arrived with the grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q         <= OWN_NONE;
            flush_pending_q <= 1'b0;
        end else begin
            owner_q         <= owner_d;
            flush_pending_q <= fetch_win && fetch_flush;
        end
    end

    // Response steering. The valids come straight from the owner register;
    // they are masked in reset so a read already in flight when reset
    // arrives never reports a response. Data holds between responses.
    always_comb begin
        fetch_valid = !rst && (owner_q == OWN_FETCH);
        ld_rvalid   = !rst && (owner_q == OWN_LOAD_RD);
        fetch_instr = fetch_instr_q;
        ld_rdata    = ld_rdata_q;
        if (fetch_valid) begin
            fetch_instr = (flush_pending_q || fetch_flush) ? NOP_INSTR : mem_rdata;
        end
        if (ld_rvalid) begin
            ld_rdata = mem_rdata;
        end
    end

    // Hold registers so returned data stays visible until the next response.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_instr_q <= 32'd0;
            ld_rdata_q    <= 32'd0;
        end else begin
            fetch_instr_q <= fetch_instr;
            ld_rdata_q    <= ld_rdata;
        end
    end

endmodule
